rcu_clk_div: RTL and testbench

- Programmable integer clock divider that consumes the RCU_RDIV register value and produces the divided peripheral/test clock enable and clock.
- Sits directly downstream of the RCU register block: RDIV field → div_i, CTRL enable → en_i.
- Divisor changes are applied only at period boundaries, so clk_o never glitches or produces a runt pulse.

---
 rtl/rcu_clk_div_pkg.sv | 29 ++
 rtl/rcu_sync2.sv | 26 ++
 rtl/rcu_clk_div.sv | 117 +++++++++++
 tb/tb_rcu_clk_div.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rcu_clk_div_pkg.sv
// Shared RCU clock-divider definitions: RDIV field geometry, FSM state
// encoding and the divisor clamp helpers used wherever RDIV is consumed.
package rcu_clk_div_pkg;

  localparam int unsigned RCU_RDIV_WIDTH   = 32;
  localparam int unsigned RCU_RDIV_MIN_VAL = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rcu_div_state_e;

  // True when a requested divisor is below the legal minimum (unsigned, full width).
  function automatic logic rcu_div_below_min(
    input logic [RCU_RDIV_WIDTH-1:0] div,
    input logic [RCU_RDIV_WIDTH-1:0] min_val
  );
    return (div < min_val);
  endfunction

  // Divisor actually applied: requests below the minimum are raised to it.
  function automatic logic [RCU_RDIV_WIDTH-1:0] rcu_eff_div(
    input logic [RCU_RDIV_WIDTH-1:0] div,
    input logic [RCU_RDIV_WIDTH-1:0] min_val
  );
    return rcu_div_below_min(div, min_val) ? min_val : div;
  endfunction

endpackage

// File: rtl/rcu_sync2.sv
// Two-flop level synchronizer with asynchronous active-low reset to 0.
// Shared by RCU stages that take control levels from another clock domain.
module rcu_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;
  logic sync;

  // Two back-to-back flops so the second stage only ever sees a settled value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d_i;
      sync <= meta;
    end
  end

  assign q_o = sync;

endmodule

// File: rtl/rcu_clk_div.sv
// Programmable integer clock divider fed by the RCU RDIV register.
// A new divisor is only loaded at a period boundary, so clk_o never glitches
// and a period is never cut short when the run request drops.
// Optional macro RCU_CLK_DIV_SYNC_EN: pass en_i through rcu_sync2 first
// (for an en_i from another clock domain; adds two cycles of start latency).
module rcu_clk_div
  import rcu_clk_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = RCU_RDIV_WIDTH,
  parameter int unsigned DIV_MIN   = RCU_RDIV_MIN_VAL
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 clk_o,
  output logic                 tick_o,
  output logic                 busy_o,
  output logic [DIV_WIDTH-1:0] div_q_o,
  output logic                 clamp_o
);

  rcu_div_state_e       state, state_next;
  logic [DIV_WIDTH-1:0] cnt, cnt_next, cnt_inc;
  logic [DIV_WIDTH-1:0] div_q, div_q_next;
  logic [DIV_WIDTH-1:0] eff_div, half, last_cnt;
  logic                 clk_q, clk_next;
  logic                 clamp_q, clamp_next;
  logic                 div_low;
  logic                 en_run;

`ifdef RCU_CLK_DIV_SYNC_EN
  rcu_sync2 u_en_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (en_i),
    .q_o     (en_run)
  );
`else
  assign en_run = en_i;
`endif

  assign div_low  = rcu_div_below_min(RCU_RDIV_WIDTH'(div_i), RCU_RDIV_WIDTH'(DIV_MIN));
  assign eff_div  = DIV_WIDTH'(rcu_eff_div(RCU_RDIV_WIDTH'(div_i), RCU_RDIV_WIDTH'(DIV_MIN)));
  assign half     = div_q >> 1;
  assign last_cnt = div_q - DIV_WIDTH'(1);
  assign cnt_inc  = cnt + DIV_WIDTH'(1);

  // State, counter, divisor and output registers; all clear asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= DIV_WIDTH'(DIV_MIN);
      clk_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      div_q   <= div_q_next;
      clk_q   <= clk_next;
      clamp_q <= clamp_next;
    end
  end

  // Next-state logic: load divisor at start/period end, otherwise count the phase.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_q_next = div_q;
    clk_next   = clk_q;
    clamp_next = clamp_q;
    case (state)
      IDLE: begin
        cnt_next = '0;
        clk_next = 1'b0;
        if (en_run) begin
          state_next = RUN;
          div_q_next = eff_div;
          clk_next   = 1'b1;
          clamp_next = clamp_q | div_low;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == last_cnt) begin
          cnt_next = '0;
          if (en_run) begin
            div_q_next = eff_div;
            clk_next   = 1'b1;
            clamp_next = clamp_q | div_low;
          end else begin
            // Last cycle of a period is always in the low phase, so clk stays 0.
            state_next = IDLE;
            clk_next   = 1'b0;
          end
        end else begin
          cnt_next = cnt_inc;
          clk_next = (cnt_inc < half);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        clk_next   = 1'b0;
      end
    endcase
  end

  assign clk_o   = clk_q;
  assign tick_o  = (state == RUN) && (cnt == last_cnt);
  assign busy_o  = (state == RUN);
  assign div_q_o = div_q;
  assign clamp_o = clamp_q;

endmodule

// File: tb/tb_rcu_clk_div.sv
// Directed self-checking bench for rcu_clk_div (default build and
// RCU_CLK_DIV_SYNC_EN build).
module tb_rcu_clk_div;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] div;
  logic        clk_o;
  logic        tick_o;
  logic        busy_o;
  logic [31:0] div_q_o;
  logic        clamp_o;

  int checks = 0;
  int errors = 0;

  rcu_clk_div dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (en),
    .div_i   (div),
    .clk_o   (clk_o),
    .tick_o  (tick_o),
    .busy_o  (busy_o),
    .div_q_o (div_q_o),
    .clamp_o (clamp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    div   = 32'd4;
    step();
    step();
    chk("rst_clk", {63'd0, clk_o}, 64'd0);
    chk("rst_tick", {63'd0, tick_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_divq", {32'd0, div_q_o}, 64'd2);
    chk("rst_clamp", {63'd0, clamp_o}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", {63'd0, busy_o}, 64'd0);

`ifdef RCU_CLK_DIV_SYNC_EN
    // One-cycle en pulse must still be captured, 3 cycles to first high.
    en = 1'b1;
    step();
    en = 1'b0;
    chk("sync_lat1_clk", {63'd0, clk_o}, 64'd0);
    step();
    chk("sync_lat2_clk", {63'd0, clk_o}, 64'd0);
    chk("sync_lat2_busy", {63'd0, busy_o}, 64'd0);
    step();
    chk("sync_busy", {63'd0, busy_o}, 64'd1);
    chk("sync_divq", {32'd0, div_q_o}, 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("sync_clk", {63'd0, clk_o}, (i < 2) ? 64'd1 : 64'd0);
      chk("sync_tick", {63'd0, tick_o}, (i == 3) ? 64'd1 : 64'd0);
      step();
    end
    chk("sync_idle_busy", {63'd0, busy_o}, 64'd0);
    chk("sync_idle_clk", {63'd0, clk_o}, 64'd0);
`else
    // div 4: pattern 1100, tick on the 4th cycle; busy one cycle after en.
    en  = 1'b1;
    div = 32'd4;
    step();
    chk("d4_busy", {63'd0, busy_o}, 64'd1);
    chk("d4_divq", {32'd0, div_q_o}, 64'd4);
    for (int i = 0; i < 8; i++) begin
      chk("d4_clk", {63'd0, clk_o}, ((i % 4) < 2) ? 64'd1 : 64'd0);
      chk("d4_tick", {63'd0, tick_o}, ((i % 4) == 3) ? 64'd1 : 64'd0);
      if (i == 7) div = 32'd5;
      step();
    end

    // div 5: 2 high / 3 low, then request 0 which clamps to 2.
    chk("d5_divq", {32'd0, div_q_o}, 64'd5);
    chk("d5_clamp", {63'd0, clamp_o}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      chk("d5_clk", {63'd0, clk_o}, ((i % 5) < 2) ? 64'd1 : 64'd0);
      chk("d5_tick", {63'd0, tick_o}, ((i % 5) == 4) ? 64'd1 : 64'd0);
      if (i == 9) div = 32'd0;
      step();
    end
    chk("d0_divq", {32'd0, div_q_o}, 64'd2);
    chk("d0_clamp", {63'd0, clamp_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("d0_clk", {63'd0, clk_o}, ((i % 2) == 0) ? 64'd1 : 64'd0);
      chk("d0_tick", {63'd0, tick_o}, ((i % 2) == 1) ? 64'd1 : 64'd0);
      if (i == 3) div = 32'd8;
      step();
    end

    // div 8 with mid-period change to 3: current period keeps 8.
    chk("d8_divq", {32'd0, div_q_o}, 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("d8_clk", {63'd0, clk_o}, (i < 4) ? 64'd1 : 64'd0);
      chk("d8_tick", {63'd0, tick_o}, (i == 7) ? 64'd1 : 64'd0);
      if (i == 2) div = 32'd3;
      if (i == 5) chk("d8_divq_hold", {32'd0, div_q_o}, 64'd8);
      step();
    end
    chk("d3_divq", {32'd0, div_q_o}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("d3_clk", {63'd0, clk_o}, (i < 1) ? 64'd1 : 64'd0);
      chk("d3_tick", {63'd0, tick_o}, (i == 2) ? 64'd1 : 64'd0);
      if (i == 2) div = 32'd6;
      step();
    end

    // div 6, en dropped at cnt 1: full 3H/3L period, then IDLE, div_q frozen.
    chk("d6_divq", {32'd0, div_q_o}, 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("d6_clk", {63'd0, clk_o}, (i < 3) ? 64'd1 : 64'd0);
      chk("d6_tick", {63'd0, tick_o}, (i == 5) ? 64'd1 : 64'd0);
      chk("d6_busy", {63'd0, busy_o}, 64'd1);
      if (i == 1) en = 1'b0;
      if (i == 5) div = 32'd9;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("off_busy", {63'd0, busy_o}, 64'd0);
      chk("off_clk", {63'd0, clk_o}, 64'd0);
      chk("off_tick", {63'd0, tick_o}, 64'd0);
      chk("off_divq", {32'd0, div_q_o}, 64'd6);
      step();
    end

    // div 10, asynchronous reset while clk_o is high.
    en  = 1'b1;
    div = 32'd10;
    step();
    step();
    step();
    chk("d10_clk_pre", {63'd0, clk_o}, 64'd1);
    chk("d10_clamp_pre", {63'd0, clamp_o}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk", {63'd0, clk_o}, 64'd0);
    chk("arst_busy", {63'd0, busy_o}, 64'd0);
    chk("arst_tick", {63'd0, tick_o}, 64'd0);
    chk("arst_divq", {32'd0, div_q_o}, 64'd2);
    chk("arst_clamp", {63'd0, clamp_o}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
